// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the pipelined adder: default geometry, chunk sizing
// and the parameter legality check used at elaboration.
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Bits handled by each pipeline stage.
    function automatic int chunk_width(input int width, input int stages);
        return (stages > 0) ? (width / stages) : 1;
    endfunction

    // The carry chain must split into equal, non-empty chunks.
    function automatic bit params_legal(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// SUB exists only when PIPELINED_ADDER_SUB_EN is defined.
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_in;
`ifdef PIPELINED_ADDER_SUB_EN
    logic             SUB;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Y;
    logic             C_out;
    logic             OVF;

    // Producer of operands / consumer of results.
    modport master (
        output in_valid,
        output A,
        output B,
        output C_in,
`ifdef PIPELINED_ADDER_SUB_EN
        output SUB,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Y,
        input  C_out,
        input  OVF
    );

    // The adder itself.
    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  C_in,
`ifdef PIPELINED_ADDER_SUB_EN
        input  SUB,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output Y,
        output C_out,
        output OVF
    );

endinterface

// File: rtl/pipelined_adder_chunk.sv
// Combinational W-bit ripple adder used as one pipeline stage's slice of the
// carry chain; also exposes the carry into its MSB for overflow detection.
module adder_chunk
    import pipelined_adder_pkg::*;
#(
    parameter int W = DEFAULT_WIDTH / DEFAULT_STAGES
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] s,
    output logic         c_out,
    output logic         c_msb_in
);

    logic [W:0] c;

    assign c[0] = c_in;

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign c_out    = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder with the carry chain split over STAGES registered chunks and
// valid/ready flow control. Define PIPELINED_ADDER_SUB_EN to add subtract mode.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);

    if (!params_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: WIDTH=%0d must be a multiple of STAGES=%0d (1..WIDTH)",
               WIDTH, STAGES);
    end

    // Per-stage pipeline registers. Operands travel whole; each stage only
    // consumes its own chunk and later stages pick up the upper bits.
    logic [WIDTH-1:0] a_reg     [STAGES];
    logic [WIDTH-1:0] b_reg     [STAGES];
    logic [WIDTH-1:0] sum_reg   [STAGES];
    logic             carry_reg [STAGES];
    logic             ovf_reg   [STAGES];
    logic             valid_reg [STAGES];

    logic             en;
    logic [WIDTH-1:0] a_entry;
    logic [WIDTH-1:0] b_entry;
    logic             c_entry;

    // Subtraction is folded into the operands at entry, so only stage 0 sees SUB.
    always_comb begin
        a_entry = bus.A;
`ifdef PIPELINED_ADDER_SUB_EN
        b_entry = bus.SUB ? ~bus.B : bus.B;
        c_entry = bus.SUB ? 1'b1   : bus.C_in;
`else
        b_entry = bus.B;
        c_entry = bus.C_in;
`endif
    end

    // Whole pipe advances together; a stalled output freezes every stage.
    assign en           = !valid_reg[STAGES-1] || bus.out_ready;
    assign bus.in_ready = en;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic [WIDTH-1:0] sum_next;
        logic             c_in;
        logic             v_in;
        logic [CHUNK-1:0] s;
        logic             co;
        logic             cmsb;

        if (gi == 0) begin : g_first
            assign a_in   = a_entry;
            assign b_in   = b_entry;
            assign c_in   = c_entry;
            assign v_in   = bus.in_valid;
            assign sum_in = '0;
        end else begin : g_next
            assign a_in   = a_reg[gi-1];
            assign b_in   = b_reg[gi-1];
            assign c_in   = carry_reg[gi-1];
            assign v_in   = valid_reg[gi-1];
            assign sum_in = sum_reg[gi-1];
        end

        adder_chunk #(
            .W(CHUNK)
        ) u_chunk (
            .a        (a_in[gi*CHUNK +: CHUNK]),
            .b        (b_in[gi*CHUNK +: CHUNK]),
            .c_in     (c_in),
            .s        (s),
            .c_out    (co),
            .c_msb_in (cmsb)
        );

        always_comb begin
            sum_next                     = sum_in;
            sum_next[gi*CHUNK +: CHUNK]  = s;
        end

        // Only the last stage's overflow flag reaches the output; the chunk
        // holding the MSB is the one whose carries define signed overflow.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_reg[gi]     <= '0;
                b_reg[gi]     <= '0;
                sum_reg[gi]   <= '0;
                carry_reg[gi] <= 1'b0;
                ovf_reg[gi]   <= 1'b0;
                valid_reg[gi] <= 1'b0;
            end else if (en) begin
                a_reg[gi]     <= a_in;
                b_reg[gi]     <= b_in;
                sum_reg[gi]   <= sum_next;
                carry_reg[gi] <= co;
                ovf_reg[gi]   <= cmsb ^ co;
                valid_reg[gi] <= v_in;
            end
        end
    end

    assign bus.out_valid = valid_reg[STAGES-1];
    assign bus.Y         = sum_reg[STAGES-1];
    assign bus.C_out     = carry_reg[STAGES-1];
    assign bus.OVF       = ovf_reg[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, STAGES=4); exercises subtract
// mode as well when PIPELINED_ADDER_SUB_EN is defined.
module tb_pipelined_adder;
    import pipelined_adder_pkg::*;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    typedef struct {
        logic [WIDTH-1:0] y;
        logic             c;
        logic             o;
        int               acc_edge;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t exp_q[$];
    exp_t cur_exp;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   lat_chk  = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference: plain integer sum, overflow from operand/result sign bits.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic cin, input logic sub);
        exp_t           m;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        logic             c0;
        bb     = sub ? ~b : b;
        c0     = sub ? 1'b1 : cin;
        full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, c0};
        m.y    = full[WIDTH-1:0];
        m.c    = full[WIDTH];
        m.o    = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
        m.acc_edge = 0;
        return m;
    endfunction

    function automatic exp_t mk(input logic [WIDTH-1:0] y, input logic c, input logic o);
        exp_t m;
        m.y = y;
        m.c = c;
        m.o = o;
        m.acc_edge = 0;
        return m;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transfers happen at the next rising edge; decide them on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) begin
                e = cur_exp;
                e.acc_edge = cyc + 1;
                exp_q.push_back(e);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("Y", 32'(bus.Y), 32'(e.y));
                    check_val("C_out", 32'(bus.C_out), 32'(e.c));
                    check_val("OVF", 32'(bus.OVF), 32'(e.o));
                    $display("txn out: Y=0x%04h C_out=%0b OVF=%0b (accepted edge %0d)",
                             bus.Y, bus.C_out, bus.OVF, e.acc_edge);
                    if (lat_chk)
                        check_val("latency", 32'(cyc + 1 - e.acc_edge), 32'(STAGES));
                end
            end
        end
    end

    task automatic set_in(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input exp_t e);
        bus.A        = a;
        bus.B        = b;
        bus.C_in     = cin;
        cur_exp      = e;
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check_val({tag, "_accept_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input exp_t e);
        set_in(a, b, cin, e);
        wait_accept("send");
    endtask

    task automatic send_rand();
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        a   = WIDTH'($urandom);
        b   = WIDTH'($urandom);
        cin = 1'($urandom_range(0, 1));
`ifdef PIPELINED_ADDER_SUB_EN
        begin
            logic s;
            s       = 1'($urandom_range(0, 1));
            bus.SUB = s;
            send(a, b, cin, model(a, b, cin, s));
        end
`else
        send(a, b, cin, model(a, b, cin, 1'b0));
`endif
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        idle(STAGES + 3);
        check_val({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] y_hold;

        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.C_in      = 1'b0;
        bus.out_ready = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
        bus.SUB       = 1'b0;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_Y", 32'(bus.Y), 32'd0);
        check_val("rst_C_out", 32'(bus.C_out), 32'd0);
        check_val("rst_OVF", 32'(bus.OVF), 32'd0);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed carry cases
        lat_chk = 1'b1;
        send(16'h00FF, 16'h0001, 1'b0, mk(16'h0100, 1'b0, 1'b0));
        send(16'hFFFF, 16'h0000, 1'b1, mk(16'h0000, 1'b1, 1'b0));
        send(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        send(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1'b1, 1'b1));
`ifdef PIPELINED_ADDER_SUB_EN
        bus.SUB = 1'b1;
        send(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        send(16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1'b1, 1'b1));
        bus.SUB = 1'b0;
`endif
        drain("directed");

        // Back-to-back random stream
        for (int i = 0; i < 8; i++) send_rand();
        drain("random");

        // Full pipe stalled by the consumer
        lat_chk       = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < STAGES; i++) send_rand();
        set_in(16'h1111, 16'h2222, 1'b0, model(16'h1111, 16'h2222, 1'b0, 1'b0));
`ifdef PIPELINED_ADDER_SUB_EN
        bus.SUB = 1'b0;
`endif
        @(negedge clk);
        y_hold = bus.Y;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check_val("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check_val("stall_Y_stable", 32'(bus.Y), 32'(y_hold));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        wait_accept("stall");
        drain("stall");

        // Reset with transactions in flight
        lat_chk = 1'b1;
        for (int i = 0; i < STAGES; i++) send_rand();
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_val("midrst_Y", 32'(bus.Y), 32'd0);
        check_val("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
`ifdef PIPELINED_ADDER_SUB_EN
        bus.SUB = 1'b0;
`endif
        for (int i = 0; i < STAGES + 4; i++) begin
            @(negedge clk);
            check_val("stale_out_valid", 32'(bus.out_valid), 32'd0);
        end
        send(16'h1234, 16'h4321, 1'b1, mk(16'h5556, 1'b0, 1'b0));
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog timeout");
    end

endmodule
